depuncturer: RTL and testbench
==============================

DEPUNCTURER -- requirements
Module: depuncturer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit, reset: synchronous, active-low.
REQ-003 The block SHALL have port start, input, 1 bit, a pulse that loads rate and begins a new coded stream at phase 0.
REQ-004 The block SHALL have port stop, input, 1 bit, a pulse that returns the block to IDLE.
REQ-005 The block SHALL have port rate, input, 2 bits: 00=1/2, 01=2/3, 10=3/4, 11 treated as 1/2; sampled only on start.
REQ-006 The block SHALL have port in_valid, input, 1 bit, serial received coded bit valid.
REQ-007 The block SHALL have port in_bit, input, 1 bit, serial received coded bit.
REQ-008 The block SHALL have port in_ready, output, 1 bit, block accepts in_bit this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit, mother-code pair valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, downstream (Viterbi) accepts pair.
REQ-011 The block SHALL have port out_a, output, 1 bit, mother-code bit A.
REQ-012 The block SHALL have port out_b, output, 1 bit, mother-code bit B.
REQ-013 The block SHALL have port erase_a, output, 1 bit, out_a is an inserted erasure (value 0).
REQ-014 The block SHALL have port erase_b, output, 1 bit, out_b is an inserted erasure (value 0).
REQ-015 The block SHALL have port phase, output, 2 bits, index of the current pair within the puncturing period.

Function
REQ-016 The FSM SHALL have states IDLE, GET_A, GET_B, OUT.
REQ-017 The puncturing period SHALL be 1 pair for rate 1/2, 2 pairs for 2/3 and 3 pairs for 3/4; phase SHALL count 0..period-1, then wrap to 0.
REQ-018 The kept-bit pattern SHALL be:
- rate 1/2: A,B on every pair.
- rate 2/3: phase0 A,B; phase1 A only (B erased).
- rate 3/4: phase0 A,B; phase1 A only (B erased); phase2 B only (A erased).
REQ-019 On start, the FSM SHALL latch rate, set phase=0 and go to GET_A.
REQ-020 On entry to a pair, the FSM SHALL go to GET_A if A is kept, else go to GET_B with erase_a=1 and out_a=0.
REQ-021 In GET_A, in_ready SHALL be 1; on in_valid&in_ready the FSM SHALL latch out_a=in_bit and go to GET_B if B is kept, else go to OUT with erase_b=1 and out_b=0.
REQ-022 In GET_B, in_ready SHALL be 1; on in_valid&in_ready the FSM SHALL latch out_b=in_bit and go to OUT.
REQ-023 in_ready SHALL be 0 in IDLE and OUT; at most one input bit SHALL be consumed per cycle.
REQ-024 In OUT, out_valid SHALL be 1 and out_a/out_b/erase_a/erase_b SHALL be held stable until out_valid&out_ready.
REQ-025 On out_valid&out_ready, phase SHALL advance with wrap and the FSM SHALL enter the next pair per REQ-020 in the following cycle.
REQ-026 out_valid SHALL assert the cycle after the last kept bit of a pair is accepted (latency 1); the pair for a given phase SHALL be complete after exactly its kept-bit count of accepted bits.
REQ-027 Throughput SHALL be one cycle per kept bit plus one OUT cycle per pair when in_valid and out_ready are held high.
REQ-028 Input stalls (in_valid=0) SHALL hold state; output stalls (out_ready=0) SHALL hold OUT indefinitely.
REQ-029 stop in any state SHALL go to IDLE next cycle, discard any partial or unaccepted pair, and clear out_valid.
REQ-030 start in a non-IDLE state SHALL restart per REQ-019, discarding any partial pair.
REQ-031 Simultaneous start and stop SHALL be resolved as start.
REQ-032 Erase flags SHALL be cleared at entry to each new pair.

Reset
REQ-033 While rst=0 at a clk edge, the block SHALL enter IDLE with phase=0, latched rate=00, out_valid=0, out_a=0, out_b=0, erase_a=0, erase_b=0 and in_ready=0.
REQ-034 Reset SHALL override start and stop, and reset mid-stream SHALL discard all partial data.

Verification
REQ-035 The bench SHALL check: rate=00, start, bits 1,0,1,1 with out_ready=1 -> pairs (A1,B0),(A1,B1), no erasures, out_valid 1 cycle after each 2nd bit.
REQ-036 The bench SHALL check: rate=10, start, bits 1,1,0,1 -> (1,1,e0/0), (0,0 eB=1), (0 eA=1,1), phase sequence 0,1,2,0.
REQ-037 The bench SHALL check: rate=01, bits 0,1,1 -> (0,1), (1,0 eB=1); phase wraps 1->0.
REQ-038 The bench SHALL check: out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0, no bits consumed; release -> next pair proceeds.
REQ-039 The bench SHALL check: stop after first bit of a pair -> IDLE next cycle, out_valid=0; a new start resumes at phase 0.
REQ-040 The bench SHALL check: rst=0 asserted in GET_B with in_valid=1 -> all outputs 0 next cycle, the bit is not latched.

Source files
------------

// File: rtl/depuncturer.sv
`default_nettype none
// ============================================================================
// depuncturer : re-inserts punctured (erased) bits to rebuild rate-1/2 pairs
// Rev 1.0
// ============================================================================
module depuncturer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] rate,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_a,
  output logic       out_b,
  output logic       erase_a,
  output logic       erase_b,
  output logic [1:0] phase
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GET_A = 2'd1;
  localparam logic [1:0] ST_GET_B = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  logic [1:0] state_q, state_d;
  logic [1:0] rate_q, rate_d;
  logic [1:0] phase_q, phase_d;
  logic       a_q, a_d, b_q, b_d;
  logic       ea_q, ea_d, eb_q, eb_d;
  logic [1:0] next_phase;
  logic       next_keep_a;
  logic       cur_keep_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rate_q  <= 2'b00;
      phase_q <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      ea_q    <= 1'b0;
      eb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
    end
  end

  always_comb begin
    // Rate code 11 falls into the default arm and behaves as rate 1/2.
    case (rate_q)
      RATE_2_3: next_phase = (phase_q == 2'd1) ? 2'd0 : phase_q + 2'd1;
      RATE_3_4: next_phase = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      default:  next_phase = 2'd0;
    endcase
    next_keep_a = !((rate_q == RATE_3_4) && (next_phase == 2'd2));
    cur_keep_b  = !(((rate_q == RATE_2_3) || (rate_q == RATE_3_4)) && (phase_q == 2'd1));

    state_d = state_q;
    rate_d  = rate_q;
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    ea_d    = ea_q;
    eb_d    = eb_q;

    if (start) begin
      rate_d  = rate;
      phase_d = 2'd0;
      state_d = ST_GET_A;
      a_d     = 1'b0;
      b_d     = 1'b0;
      ea_d    = 1'b0;
      eb_d    = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      a_d     = 1'b0;
      b_d     = 1'b0;
      ea_d    = 1'b0;
      eb_d    = 1'b0;
    end else begin
      case (state_q)
        ST_GET_A: if (in_valid) begin
          a_d = in_bit;
          if (cur_keep_b) begin
            state_d = ST_GET_B;
          end else begin
            state_d = ST_OUT;
            b_d     = 1'b0;
            eb_d    = 1'b1;
          end
        end
        ST_GET_B: if (in_valid) begin
          b_d     = in_bit;
          state_d = ST_OUT;
        end
        ST_OUT: if (out_ready) begin
          phase_d = next_phase;
          a_d     = 1'b0;
          b_d     = 1'b0;
          eb_d    = 1'b0;
          ea_d    = !next_keep_a;
          state_d = next_keep_a ? ST_GET_A : ST_GET_B;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_GET_A) || (state_q == ST_GET_B);
    out_valid = (state_q == ST_OUT);
    out_a     = a_q;
    out_b     = b_q;
    erase_a   = ea_q;
    erase_b   = eb_q;
    phase     = phase_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_depuncturer.sv
`default_nettype none
// ============================================================================
// tb_depuncturer : scoreboard bench with a pattern-table reference model
// Rev 1.0
// ============================================================================
module tb_depuncturer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] rate = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_a, out_b, erase_a, erase_b;
  logic [1:0] phase;

  depuncturer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rate(rate),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .erase_a(erase_a), .erase_b(erase_b), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       ea;
    logic       eb;
    logic [1:0] ph;
  } pair_t;

  pair_t exp_q[$];
  pair_t e;
  int    errors = 0;
  int    checks = 0;
  int    m_rate = 0;
  int    m_phase = 0;
  int    m_got = 0;
  logic  m_a = 1'b0;
  logic  m_b = 1'b0;
  bit    exp_ov = 1'b0;
  bit    rand_ready = 1'b0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Puncturing tables: period and which mother-code bits survive per phase.
  function automatic int period(input int r);
    case (r)
      1:       return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit keeps_a(input int r, input int p);
    return !(r == 2 && p == 2);
  endfunction

  function automatic bit keeps_b(input int r, input int p);
    return !((r == 1 || r == 2) && p == 1);
  endfunction

  function automatic void m_start(input int r);
    m_rate  = r;
    m_phase = 0;
    m_got   = 0;
  endfunction

  function automatic void m_feed(input logic v);
    bit ka, kb;
    int need;
    ka   = keeps_a(m_rate, m_phase);
    kb   = keeps_b(m_rate, m_phase);
    need = int'(ka) + int'(kb);
    if (m_got == 0 && ka) m_a = v;
    else m_b = v;
    m_got++;
    if (m_got == need) begin
      exp_q.push_back(pair_t'({ka ? m_a : 1'b0, kb ? m_b : 1'b0, !ka, !kb, 2'(m_phase)}));
      m_phase = (m_phase + 1) % period(m_rate);
      m_got   = 0;
      exp_ov  = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    #1;
    if (exp_ov) begin
      chk("latency_out_valid", {7'b0, out_valid}, 8'd1);
      exp_ov = 1'b0;
    end
    if (out_valid) chk("in_ready_during_out", {7'b0, in_ready}, 8'd0);
    if (out_valid && out_ready && rst && !start && !stop) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pair: DUT emitted %b%b%b%b ph%0d but none expected", out_a, out_b, erase_a, erase_b, phase);
      end else begin
        e = exp_q.pop_front();
        chk("pair", {2'b0, out_a, out_b, erase_a, erase_b, phase}, {2'b0, e});
      end
    end
    if (in_valid && in_ready && rst && !start && !stop) m_feed(in_bit);
  end

  task automatic do_start(input logic [1:0] r);
    @(negedge clk);
    rate     = r;
    start    = 1'b1;
    in_valid = 1'b0;
    m_start(int'(r));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic b, input bit bubbles);
    int guard = 0;
    do begin
      if (guard != 0 || 1'b1) @(negedge clk);
      in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_bit   = b;
      guard++;
    end while (!(in_valid && in_ready) && guard < 300);
    if (guard >= 300) chk("send_timeout", 8'd1, 8'd0);
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) chk("drain_timeout", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic send_list(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs", {out_valid, in_ready, out_a, out_b, erase_a, erase_b, phase}, 8'd0);
    rst = 1'b1;

    // Rate 1/2: bits 1,0,1,1
    do_start(2'b00);
    send_list(8'b0000_1011, 4);
    drain();

    // Rate 3/4: bits 1,1,0,1 then phase wraps to 0
    do_start(2'b10);
    send_list(8'b0000_1101, 4);
    drain();
    #1;
    chk("phase_wrap_34", {6'b0, phase}, 8'd0);

    // Rate 2/3: bits 0,1,1 then phase wraps 1->0
    do_start(2'b01);
    send_list(8'b0000_0011, 3);
    drain();
    #1;
    chk("phase_wrap_23", {6'b0, phase}, 8'd0);

    // Output stall with input offered: nothing consumed, outputs frozen
    out_ready = 1'b0;
    do_start(2'b00);
    send_list(8'b0000_0010, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      #1;
      chk("stall_hold", {out_valid, in_ready, out_a, out_b, erase_a, erase_b, phase}, 8'b1010_0000);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_list(8'b0000_0011, 2);
    drain();

    // Stop after first bit of a pair, then restart at phase 0
    do_start(2'b01);
    send(1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    stop     = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_idle", {6'b0, out_valid, in_ready}, 8'd0);
    do_start(2'b10);
    send_list(8'b0000_0010, 2);
    drain();

    // Stop while a pair is waiting in OUT discards it
    out_ready = 1'b0;
    do_start(2'b00);
    send_list(8'b0000_0001, 2);
    @(negedge clk);
    in_valid = 1'b0;
    stop     = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_in_out", {6'b0, out_valid, in_ready}, 8'd0);
    exp_q.delete();
    out_ready = 1'b1;

    // Simultaneous start and stop resolves as start
    @(negedge clk);
    rate  = 2'b00;
    start = 1'b1;
    stop  = 1'b1;
    m_start(0);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    #1;
    chk("start_beats_stop", {7'b0, in_ready}, 8'd1);
    send_list(8'b0000_0011, 2);
    drain();

    // Restart mid-pair discards the partial pair
    do_start(2'b10);
    send(1'b1, 1'b0);
    do_start(2'b01);
    send_list(8'b0000_0101, 3);
    drain();

    // Reset in GET_B with a valid bit present: bit is dropped
    do_start(2'b00);
    send(1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    rst      = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_midstream", {out_valid, in_ready, out_a, out_b, erase_a, erase_b, phase}, 8'd0);
    rst      = 1'b1;
    in_valid = 1'b0;

    // Randomized streams with input bubbles and output backpressure
    rand_ready = 1'b1;
    for (int s = 0; s < 12; s++) begin
      do_start(2'($urandom_range(0, 3)));
      for (int i = 0; i < int'($urandom_range(3, 20)); i++) send(1'($urandom_range(0, 1)), 1'b1);
      drain();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
